// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator's binary-to-BCD display path.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam int BIN_W        = 16;
  localparam int DIGIT_W      = 4;
  localparam int NUM_DIGITS   = 5;
  localparam int ACC_W        = DIGIT_W * NUM_DIGITS;
  localparam int DISP_W       = 16;
  localparam int SHIFT_CYCLES = 16;
  localparam int CNT_W        = 5;
  localparam int MAX_DISPLAY  = 9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  always_comb begin
    if (digit >= DIGIT_W'(5)) adj = digit + DIGIT_W'(3);
    else                      adj = digit;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to packed BCD converter, one shift-and-add-3 step
// per cycle; the output register holds the last full result for the display.
//
// state | meaning
// IDLE  | waiting for start, bcd_out holds last result
// SHIFT | 16 adjust-and-shift iterations
// LOAD  | publish accumulator to bcd_out/overflow, pulse done
module bin_to_bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        overflow
);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               last_shift;
  logic               unused_top_carry;

  assign last_shift = (cnt == CNT_W'(SHIFT_CYCLES - 1));

  // A 16-bit input never reaches 100000, so the top digit's MSB is never shifted out.
  assign unused_top_carry = acc_adj[ACC_W-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc[i*DIGIT_W +: DIGIT_W]),
      .adj   (acc_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin_in;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          acc   <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt + CNT_W'(1);
        end
        LOAD: begin
          bcd_out  <= acc[DISP_W-1:0];
          overflow <= (acc[ACC_W-1 -: DIGIT_W] != '0);
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int unsigned last_val = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  function automatic logic [15:0] model_bcd(input int unsigned v);
    int unsigned m;
    m = v % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic model_ovf(input int unsigned v);
    return v > 9999;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and waits (bounded) for done; lat=-1 on timeout.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cnt);
    start  = 1'b1;
    bin_in = v;
    step();
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      bin_in = 16'($urandom);
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b1; bin_in = 16'h04D2;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    clr = 1'b0; start = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_wins_busy: got %0b want 0", busy); end
  endtask

  task automatic test_zero();
    int lat, bc;
    run_conv(16'd0, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL zero_latency: got %0d want 17", lat); end
    total++; if (bcd_out !== model_bcd(0)) begin bad++; $display("FAIL zero_bcd: got %h want %h", bcd_out, model_bcd(0)); end
    total++; if (overflow !== model_ovf(0)) begin bad++; $display("FAIL zero_ovf: got %0b want %0b", overflow, model_ovf(0)); end
    last_val = 0;
  endtask

  task automatic test_1234();
    int lat, bc;
    run_conv(16'h04D2, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL 1234_latency: got %0d want 17", lat); end
    total++; if (bc !== 17) begin bad++; $display("FAIL 1234_busy_cycles: got %0d want 17", bc); end
    total++; if (bcd_out !== model_bcd(1234)) begin bad++; $display("FAIL 1234_bcd: got %h want %h", bcd_out, model_bcd(1234)); end
    total++; if (overflow !== model_ovf(1234)) begin bad++; $display("FAIL 1234_ovf: got %0b want %0b", overflow, model_ovf(1234)); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %0b want 0", done); end
    last_val = 1234;
  endtask

  task automatic test_boundaries();
    int unsigned vals[4] = '{9999, 10000, 65535, 9998};
    int lat, bc;
    foreach (vals[i]) begin
      run_conv(16'(vals[i]), lat, bc);
      total++; if (bcd_out !== model_bcd(vals[i])) begin bad++; $display("FAIL bound_bcd[%0d]: got %h want %h", vals[i], bcd_out, model_bcd(vals[i])); end
      total++; if (overflow !== model_ovf(vals[i])) begin bad++; $display("FAIL bound_ovf[%0d]: got %0b want %0b", vals[i], overflow, model_ovf(vals[i])); end
      last_val = vals[i];
    end
  endtask

  task automatic test_random();
    int lat, bc;
    int unsigned v;
    for (int n = 0; n < 16; n++) begin
      v = $urandom_range(0, 65535);
      run_conv(16'(v), lat, bc);
      total++; if (lat !== 17) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 17", v, lat); end
      total++; if (bcd_out !== model_bcd(v)) begin bad++; $display("FAIL rand_bcd[%0d]: got %h want %h", v, bcd_out, model_bcd(v)); end
      total++; if (overflow !== model_ovf(v)) begin bad++; $display("FAIL rand_ovf[%0d]: got %0b want %0b", v, overflow, model_ovf(v)); end
      last_val = v;
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic hold_ok = 1'b1;
    logic [15:0] first_bcd = 16'hxxxx;
    start = 1'b1; bin_in = 16'd42;
    step();
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      start = (c == 4);
      bin_in = (c == 4) ? 16'd7 : 16'($urandom);
      if (done) begin
        if (dones == 0) first_bcd = bcd_out;
        dones++;
      end else if (dones == 0 && bcd_out !== model_bcd(last_val)) begin
        hold_ok = 1'b0;
      end
      step();
    end
    start = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    total++; if (first_bcd !== model_bcd(42)) begin bad++; $display("FAIL ignore_bcd: got %h want %h", first_bcd, model_bcd(42)); end
    total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL ignore_hold_prev: got %0b want 1", hold_ok); end
    last_val = 42;
  endtask

  task automatic test_clr_abort();
    int lat, bc;
    logic saw_done = 1'b0;
    start = 1'b1; bin_in = 16'd5000;
    step();
    start = 1'b0;
    for (int c = 0; c < 7; c++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %0b want 0", done); end
    total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL abort_bcd: got %h want 0000", bcd_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL abort_ovf: got %0b want 0", overflow); end
    for (int c = 0; c < 30; c++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %0b want 0", saw_done); end
    run_conv(16'd777, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL after_abort_latency: got %0d want 17", lat); end
    total++; if (bcd_out !== model_bcd(777)) begin bad++; $display("FAIL after_abort_bcd: got %h want %h", bcd_out, model_bcd(777)); end
    last_val = 777;
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    logic hold_ok = 1'b1;
    logic pre_ok = 1'b1;
    start = 1'b1; bin_in = 16'd321;
    step();
    for (int c = 0; c < 80; c++) begin
      if (done) done_at.push_back(c);
      if (done_at.size() == 0) begin
        if (bcd_out !== model_bcd(last_val)) pre_ok = 1'b0;
      end else if (bcd_out !== model_bcd(321) || overflow !== model_ovf(321)) begin
        hold_ok = 1'b0;
      end
      step();
    end
    start = 1'b0;
    total++; if (done_at.size() !== 4) begin bad++; $display("FAIL b2b_done_count: got %0d want 4", done_at.size()); end
    if (done_at.size() > 0) begin
      total++; if (done_at[0] !== 17) begin bad++; $display("FAIL b2b_first_done: got %0d want 17", done_at[0]); end
    end
    for (int i = 1; i < done_at.size(); i++) begin
      total++; if (done_at[i] - done_at[i-1] !== 18) begin bad++; $display("FAIL b2b_period[%0d]: got %0d want 18", i, done_at[i] - done_at[i-1]); end
    end
    total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL b2b_bcd_hold: got %0b want 1", hold_ok); end
    total++; if (pre_ok !== 1'b1) begin bad++; $display("FAIL b2b_pre_hold: got %0b want 1", pre_ok); end
    for (int c = 0; c < 25; c++) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: got %0b want 0", busy); end
    last_val = 321;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; bin_in = 16'd0;
    test_reset();
    test_zero();
    test_1234();
    test_boundaries();
    test_random();
    test_ignore_start();
    test_clr_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
